// File: rtl/coord_entry_buffer.sv
// Coordinate intake: synchronizes and debounces ENTER, then stores (X,Y) pairs
// in entry order. A (0,0) entry empties the buffer.
module coord_entry_buffer #(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 4,
    parameter int DB_COUNT = 50000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          X,
    input  logic [DATA_W-1:0]          Y,
    input  logic                       enter,
    output logic [DEPTH*DATA_W-1:0]    pairs_x,
    output logic [DEPTH*DATA_W-1:0]    pairs_y,
    output logic [DEPTH-1:0]           valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       new_pair,
    output logic                       cleared,
    output logic                       overflow
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int DBW = $clog2(DB_COUNT + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_COUNT - 1);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } state_t;

    logic              enter_s1_q, enter_s_q;
    logic [DATA_W-1:0] x_s1_q, x_s_q, y_s1_q, y_s_q;
    logic [DBW-1:0]    db_cnt_q, arm_cnt_q;
    logic              db_level_q, db_prev_q, armed_q, press_q;

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [DEPTH*DATA_W-1:0] px_q, px_d, py_q, py_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic new_pair_q, new_pair_d;
    logic cleared_q, cleared_d;
    logic overflow_q, overflow_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            enter_s1_q <= 1'b0;
            enter_s_q  <= 1'b0;
            x_s1_q     <= '0;
            x_s_q      <= '0;
            y_s1_q     <= '0;
            y_s_q      <= '0;
            db_cnt_q   <= '0;
            arm_cnt_q  <= '0;
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
            armed_q    <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            enter_s1_q <= enter;
            enter_s_q  <= enter_s1_q;
            x_s1_q     <= X;
            x_s_q      <= x_s1_q;
            y_s1_q     <= Y;
            y_s_q      <= y_s1_q;
            if (enter_s_q != db_level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    db_level_q <= enter_s_q;
                    db_cnt_q   <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
            // Arm only after a full quiet-low period, so a held button never fires
            if (!db_level_q && !enter_s_q) begin
                if (arm_cnt_q == DB_LAST) begin
                    armed_q <= 1'b1;
                end else begin
                    arm_cnt_q <= arm_cnt_q + 1'b1;
                end
            end else begin
                arm_cnt_q <= '0;
            end
            db_prev_q <= db_level_q;
            press_q   <= armed_q & db_level_q & ~db_prev_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= EMPTY;
            count_q    <= '0;
            px_q       <= '0;
            py_q       <= '0;
            valid_q    <= '0;
            new_pair_q <= 1'b0;
            cleared_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            px_q       <= px_d;
            py_q       <= py_d;
            valid_q    <= valid_d;
            new_pair_q <= new_pair_d;
            cleared_q  <= cleared_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        px_d       = px_q;
        py_d       = py_q;
        valid_d    = valid_q;
        new_pair_d = 1'b0;
        cleared_d  = 1'b0;
        overflow_d = 1'b0;
        if (press_q) begin
            if (x_s_q == '0 && y_s_q == '0) begin
                state_d   = EMPTY;
                count_d   = '0;
                px_d      = '0;
                py_d      = '0;
                valid_d   = '0;
                cleared_d = 1'b1;
            end else if (state_q != FULL) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (count_q == CW'(i)) begin
                        px_d[i*DATA_W +: DATA_W] = x_s_q;
                        py_d[i*DATA_W +: DATA_W] = y_s_q;
                        valid_d[i]               = 1'b1;
                    end
                end
                count_d    = count_q + 1'b1;
                state_d    = (count_d == CW'(DEPTH)) ? FULL : FILLING;
                new_pair_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    assign pairs_x  = px_q;
    assign pairs_y  = py_q;
    assign valid    = valid_q;
    assign count    = count_q;
    assign full     = (state_q == FULL);
    assign new_pair = new_pair_q;
    assign cleared  = cleared_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_coord_entry_buffer.sv
// Bench for coord_entry_buffer: directed press scenarios plus random presses
// checked against a queue model of the stored pairs.
module tb_coord_entry_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 4;
    localparam int DBC   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enter = 1'b0;
    logic [DW-1:0]     X = '0;
    logic [DW-1:0]     Y = '0;
    logic [DEPTH*DW-1:0] pairs_x, pairs_y;
    logic [DEPTH-1:0]  valid;
    logic [2:0]        count;
    logic              full, new_pair, cleared, overflow;

    int total = 0;
    int bad   = 0;
    int np_n  = 0;
    int cl_n  = 0;
    int ov_n  = 0;
    logic [7:0] mq[$];

    coord_entry_buffer #(
        .DEPTH(DEPTH), .DATA_W(DW), .DB_COUNT(DBC)
    ) dut (
        .clock(clk), .reset(rst), .X(X), .Y(Y), .enter(enter),
        .pairs_x(pairs_x), .pairs_y(pairs_y), .valid(valid),
        .count(count), .full(full), .new_pair(new_pair),
        .cleared(cleared), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (new_pair) np_n++;
        if (cleared)  cl_n++;
        if (overflow) ov_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [DEPTH*DW-1:0] ex, ey;
        logic [DEPTH-1:0]    ev;
        ex = '0;
        ey = '0;
        ev = '0;
        for (int i = 0; i < mq.size(); i++) begin
            ex[i*DW +: DW] = mq[i][7:4];
            ey[i*DW +: DW] = mq[i][3:0];
            ev[i]          = 1'b1;
        end
        chk({tag, "_count"}, 32'(count), 32'(mq.size()));
        chk({tag, "_valid"}, 32'(valid), 32'(ev));
        chk({tag, "_full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, "_px"}, 32'(pairs_x), 32'(ex));
        chk({tag, "_py"}, 32'(pairs_y), 32'(ey));
    endtask

    task automatic do_press(input logic [3:0] x, input logic [3:0] y,
                            input bit bounce, input string tag);
        int np0, cl0, ov0;
        int e_np, e_cl, e_ov;
        bit seen;
        e_np = 0;
        e_cl = 0;
        e_ov = 0;
        seen = 0;
        if (x == 0 && y == 0) begin
            mq.delete();
            e_cl = 1;
        end else if (mq.size() < DEPTH) begin
            mq.push_back({x, y});
            e_np = 1;
        end else begin
            e_ov = 1;
        end
        @(negedge clk);
        X = x;
        Y = y;
        repeat (4) @(negedge clk);
        np0 = np_n;
        cl0 = cl_n;
        ov0 = ov_n;
        if (bounce) begin
            for (int i = 0; i < 20; i++) begin
                enter = ~enter;
                @(negedge clk);
            end
        end
        enter = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk);
            if (np_n != np0 || cl_n != cl0 || ov_n != ov0) seen = 1;
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        enter = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        chk({tag, "_np"}, 32'(np_n - np0), 32'(e_np));
        chk({tag, "_cl"}, 32'(cl_n - cl0), 32'(e_cl));
        chk({tag, "_ov"}, 32'(ov_n - ov0), 32'(e_ov));
        check_state(tag);
    endtask

    initial begin
        int np0;
        logic [3:0] rx, ry;

        rst   = 1'b1;
        enter = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_state("rst");
        chk("rst_pulses", 32'({new_pair, cleared, overflow}), 32'd0);

        np0 = np_n;
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        enter = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("held_np", 32'(np_n - np0), 32'd0);
        check_state("held");

        do_press(4'd3, 4'd7, 1'b1, "bounce");
        chk("bounce_x0", 32'(pairs_x[3:0]), 32'd3);
        chk("bounce_y0", 32'(pairs_y[3:0]), 32'd7);

        do_press(4'd0, 4'd0, 1'b0, "clr0");
        do_press(4'd1, 4'd2, 1'b0, "p1");
        do_press(4'd3, 4'd4, 1'b0, "p2");
        do_press(4'd5, 4'd6, 1'b0, "p3");
        do_press(4'd7, 4'd8, 1'b0, "p4");
        chk("p4_slot3x", 32'(pairs_x[15:12]), 32'd7);
        chk("p4_slot3y", 32'(pairs_y[15:12]), 32'd8);
        do_press(4'd9, 4'd9, 1'b0, "ovf");
        do_press(4'd0, 4'd0, 1'b0, "clrfull");
        do_press(4'd2, 4'd8, 1'b0, "after_clr");
        do_press(4'd0, 4'd0, 1'b0, "clr1");

        do_press(4'd1, 4'd1, 1'b0, "r1");
        do_press(4'd2, 4'd2, 1'b0, "r2");
        @(negedge clk);
        rst = 1'b1;
        mq.delete();
        @(negedge clk);
        rst   = 1'b0;
        enter = 1'b1;
        X     = 4'd5;
        Y     = 4'd5;
        #1;
        check_state("midrst");
        np0 = np_n;
        repeat (20) @(negedge clk);
        enter = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        chk("unarmed_np", 32'(np_n - np0), 32'd0);
        check_state("unarmed");
        do_press(4'd5, 4'd5, 1'b0, "rearmed");

        for (int k = 0; k < 30; k++) begin
            rx = 4'($urandom_range(0, 15));
            ry = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) begin
                rx = '0;
                ry = '0;
            end
            do_press(rx, ry, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
